io_bus_ctrl: RTL

IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

---
 rtl/io_bus_ctrl_if.sv | 35 +++
 rtl/io_bus_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/io_bus_ctrl_if.sv
// CPU-side request/response bus plus the device-side select/ready bus of io_bus_ctrl.
// Handshake: the CPU pulses cpu_req for one cycle while cpu_busy is low; the controller answers
// with a one-cycle cpu_ack (cpu_err qualifies it). Devices see a one-cycle io_req with io_cs held
// until their io_rdy bit is seen or the wait times out.
interface io_bus_ctrl_if;
    logic        cpu_req;
    logic        cpu_rnw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_busy;
    logic        cpu_ack;
    logic        cpu_err;
    logic [7:0]  cpu_rd_data;
    logic [7:0]  io_addr;
    logic [7:0]  io_wr_data;
    logic        io_rnw;
    logic [3:0]  io_cs;
    logic        io_req;
    logic [31:0] io_rd_data;
    logic [3:0]  io_rdy;
    logic [7:0]  err_count;

    // The controller is the slave of the CPU request stream.
    modport slave (
        input  cpu_req, cpu_rnw, cpu_addr, cpu_wr_data, io_rd_data, io_rdy,
        output cpu_busy, cpu_ack, cpu_err, cpu_rd_data, io_addr, io_wr_data,
        output io_rnw, io_cs, io_req, err_count
    );

    modport master (
        output cpu_req, cpu_rnw, cpu_addr, cpu_wr_data, io_rd_data, io_rdy,
        input  cpu_busy, cpu_ack, cpu_err, cpu_rd_data, io_addr, io_wr_data,
        input  io_rnw, io_cs, io_req, err_count
    );
endinterface

// File: rtl/io_bus_ctrl.sv
// Bridges single-cycle CPU requests to four IO devices with per-device ready and a wait timeout.
// Window misses and timeouts complete with cpu_err and read data 8'hFF.
module io_bus_ctrl #(
    parameter logic [5:0] IO_BASE = 6'h3F,
    parameter logic [7:0] TIMEOUT = 8'd16
) (
    input  logic         clk,
    input  logic         reset_,
    io_bus_ctrl_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] sel;
    logic [7:0] tmo_cnt;
    logic       hit;
    logic       sel_rdy;
    logic [7:0] sel_data;

    assign hit       = (bus.cpu_addr[15:10] == IO_BASE);
    assign sel_rdy   = bus.io_rdy[sel];
    assign sel_data  = bus.io_rd_data[{sel, 3'b000} +: 8];
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state           <= IDLE;
            sel             <= 2'd0;
            tmo_cnt         <= 8'd0;
            bus.io_req      <= 1'b0;
            bus.io_cs       <= 4'b0000;
            bus.io_rnw      <= 1'b1;
            bus.io_addr     <= 8'd0;
            bus.io_wr_data  <= 8'd0;
            bus.cpu_ack     <= 1'b0;
            bus.cpu_err     <= 1'b0;
            bus.cpu_busy    <= 1'b0;
            bus.cpu_rd_data <= 8'd0;
            bus.err_count   <= 8'd0;
        end else begin
            bus.io_req  <= 1'b0;
            bus.cpu_ack <= 1'b0;
            bus.cpu_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        bus.cpu_busy <= 1'b1;
                        if (hit) begin
                            state          <= ISSUE;
                            sel            <= bus.cpu_addr[9:8];
                            bus.io_addr    <= bus.cpu_addr[7:0];
                            bus.io_wr_data <= bus.cpu_wr_data;
                            bus.io_rnw     <= bus.cpu_rnw;
                            bus.io_cs      <= 4'b0001 << bus.cpu_addr[9:8];
                            bus.io_req     <= 1'b1;
                        end else begin
                            state           <= RESP;
                            bus.cpu_ack     <= 1'b1;
                            bus.cpu_err     <= 1'b1;
                            bus.cpu_rd_data <= 8'hFF;
                        end
                    end
                end
                ISSUE: begin
                    tmo_cnt <= 8'd0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // Ready is checked before the timeout so a last-cycle answer still succeeds.
                    if (sel_rdy) begin
                        state       <= RESP;
                        bus.io_cs   <= 4'b0000;
                        bus.cpu_ack <= 1'b1;
                        if (bus.io_rnw) begin
                            bus.cpu_rd_data <= sel_data;
                        end
                    end else if (tmo_cnt == TIMEOUT - 8'd1) begin
                        state           <= RESP;
                        bus.io_cs       <= 4'b0000;
                        bus.cpu_ack     <= 1'b1;
                        bus.cpu_err     <= 1'b1;
                        bus.cpu_rd_data <= 8'hFF;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    bus.cpu_busy <= 1'b0;
                    if (bus.cpu_err && bus.err_count != 8'hFF) begin
                        bus.err_count <= bus.err_count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
